// File: rtl/vec_alu_pkg.sv
// Shared definitions for the vector ALU datapath: default geometry, opcodes,
// flag bit positions and the writeback FSM state type.
package vec_alu_pkg;

  localparam int VEC_N  = 18;
  localparam int VEC_V  = 3;
  localparam int VEC_AW = 16;

  localparam logic [2:0] OP_SUM = 3'b101;

  localparam int FLAG_V = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef logic [VEC_V-1:0][VEC_N-1:0] vec_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } wb_state_e;

  // A reduction leaves its whole answer in lane 0.
  function automatic logic is_reduction(input logic [2:0] op);
    return op == OP_SUM;
  endfunction

endpackage

// File: rtl/vec_result_writeback.sv
// Accepts one vector ALU result per handshake and writes its lanes, one word
// per beat, to the scalar pixel-memory port; keeps the last accepted flags.
module vec_result_writeback
  import vec_alu_pkg::*;
#(
  parameter int N  = VEC_N,
  parameter int V  = VEC_V,
  parameter int AW = VEC_AW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [V-1:0][N-1:0] in_result,
  input  logic [3:0]          in_flags,
  input  logic [2:0]          in_op,
  input  logic [AW-1:0]       in_addr,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [N-1:0]        mem_wdata,
  input  logic                mem_ready,
  output logic [3:0]          flags_q,
  output logic                busy,
  output logic                done,
  output wb_state_e           fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // The producer holds its payload stable until then; in_ready never depends
  // on in_valid, and mem_we/mem_addr/mem_wdata hold steady while mem_ready=0.

  localparam int LW = (V > 1) ? $clog2(V) : 1;
  localparam logic [LW-1:0] LAST_FULL = LW'(V - 1);

  wb_state_e           state, state_nx;
  logic [LW-1:0]       lane, last_lane;
  logic [V-1:0][N-1:0] lat_result;
  logic [AW-1:0]       base;
  logic                accept, beat, final_beat;

  assign accept     = in_valid && in_ready;
  assign beat       = (state == ST_WRITE) && mem_ready;
  assign final_beat = beat && (lane == last_lane);
  assign fsm_state  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (in_valid) state_nx = ST_WRITE;
      ST_WRITE: if (final_beat) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Every output is decoded from registers only, so a stalled beat cannot move.
  always_comb begin
    in_ready  = (state == ST_IDLE) && rst_n;
    busy      = (state == ST_WRITE);
    mem_we    = busy;
    mem_addr  = busy ? base + AW'(lane) : '0;
    mem_wdata = busy ? lat_result[lane] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_result <= '0;
      base       <= '0;
      flags_q    <= 4'b0000;
      lane       <= '0;
      last_lane  <= '0;
      done       <= 1'b0;
    end else begin
      done <= final_beat;
      if (accept) begin
        lat_result <= in_result;
        base       <= in_addr;
        flags_q    <= in_flags;
        lane       <= '0;
        last_lane  <= is_reduction(in_op) ? '0 : LAST_FULL;
      end else if (beat && !final_beat) begin
        lane <= lane + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vec_result_writeback.sv
// Self-checking bench for vec_result_writeback: directed scenarios plus
// randomized transactions against a lane-by-lane expected-beat model.
module tb_vec_result_writeback;
  import vec_alu_pkg::*;

  localparam int N  = 18;
  localparam int V  = 3;
  localparam int AW = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [V-1:0][N-1:0] in_result = '0;
  logic [3:0]          in_flags = '0;
  logic [2:0]          in_op = '0;
  logic [AW-1:0]       in_addr = '0;
  logic                mem_we;
  logic [AW-1:0]       mem_addr;
  logic [N-1:0]        mem_wdata;
  logic                mem_ready = 1'b0;
  logic [3:0]          flags_q;
  logic                busy;
  logic                done;
  wb_state_e           fsm_state;

  int n_pass  = 0;
  int n_total = 0;
  logic [AW+N-1:0] exp_q[$];

  vec_result_writeback #(.N(N), .V(V), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_flags(in_flags), .in_op(in_op), .in_addr(in_addr),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .flags_q(flags_q), .busy(busy), .done(done), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a transaction produces (base+i mod 2^AW, lane i) for i < beat count.
  task automatic load_model(input logic [V-1:0][N-1:0] r, input logic [2:0] op,
                            input logic [AW-1:0] a);
    logic [AW-1:0] ea;
    int nb;
    nb = (op == 3'b101) ? 1 : V;
    for (int i = 0; i < nb; i++) begin
      ea = a + AW'(i);
      exp_q.push_back({ea, r[i]});
    end
  endtask

  task automatic run_txn(input string tag, input logic [V-1:0][N-1:0] r,
                         input logic [3:0] f, input logic [2:0] op,
                         input logic [AW-1:0] a, input int stall_pct);
    int nb, cyc;
    logic rdy;
    logic [AW+N-1:0] e;
    exp_q.delete();
    load_model(r, op, a);
    nb = exp_q.size();
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL %s in_ready_at_start got %b exp 1", tag, in_ready);
    else n_pass++;
    in_valid = 1'b1; in_result = r; in_flags = f; in_op = op; in_addr = a;
    mem_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    cyc = 1;
    n_total++;
    if (flags_q !== f) $display("FAIL %s flags_q got %b exp %b", tag, flags_q, f);
    else n_pass++;
    while (exp_q.size() > 0 && cyc < 500) begin
      e = exp_q[0];
      n_total++;
      if (mem_we !== 1'b1 || {mem_addr, mem_wdata} !== e)
        $display("FAIL %s beat got we=%b %h/%h exp we=1 %h/%h", tag, mem_we, mem_addr,
                 mem_wdata, e[AW+N-1:N], e[N-1:0]);
      else n_pass++;
      n_total++;
      if (done !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1)
        $display("FAIL %s busy_flags got done=%b rdy=%b busy=%b exp 0,0,1", tag, done,
                 in_ready, busy);
      else n_pass++;
      rdy = ($urandom_range(99) >= stall_pct);
      mem_ready = rdy;
      tick();
      cyc++;
      if (rdy) void'(exp_q.pop_front());
    end
    n_total++;
    if (exp_q.size() != 0) $display("FAIL %s timeout beats_left got %0d exp 0", tag, exp_q.size());
    else n_pass++;
    n_total++;
    if (done !== 1'b1 || mem_we !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL %s end got done=%b we=%b rdy=%b exp 1,0,1", tag, done, mem_we, in_ready);
    else n_pass++;
    if (stall_pct == 0) begin
      n_total++;
      if (cyc != nb + 1) $display("FAIL %s latency got %0d exp %0d", tag, cyc, nb + 1);
      else n_pass++;
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_total++;
    if (in_ready !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_hold got rdy=%b we=%b busy=%b done=%b exp 0,0,0,0", in_ready,
               mem_we, busy, done);
    else n_pass++;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_total++;
    if (in_ready !== 1'b1 || mem_addr !== '0 || mem_wdata !== '0 || flags_q !== 4'b0)
      $display("FAIL reset_release got rdy=%b addr=%h data=%h flags=%b exp 1,0,0,0",
               in_ready, mem_addr, mem_wdata, flags_q);
    else n_pass++;
  endtask

  task automatic test_add();
    run_txn("add", {18'h3, 18'h2, 18'h1}, 4'b0001, 3'b000, 16'h0010, 0);
  endtask

  task automatic test_sum();
    run_txn("sum", {18'h3ABCD, 18'h12345, 18'h00006}, 4'b0100, 3'b101, 16'h0040, 0);
  endtask

  task automatic test_wrap();
    run_txn("wrap", {18'h0AAAA, 18'h15555, 18'h2F0F0}, 4'b1000, 3'b011, 16'hFFFF, 0);
  endtask

  task automatic test_stall();
    logic [V-1:0][N-1:0] r;
    r = {18'h30003, 18'h20002, 18'h10001};
    in_valid = 1'b1; in_result = r; in_flags = 4'b0011; in_op = 3'b001; in_addr = 16'h0200;
    mem_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_total++;
    if ({mem_addr, mem_wdata} !== {16'h0200, 18'h10001})
      $display("FAIL stall_lane0 got %h/%h exp 0200/10001", mem_addr, mem_wdata);
    else n_pass++;
    tick();
    for (int k = 0; k < 3; k++) begin
      mem_ready = 1'b0;
      n_total++;
      if (mem_we !== 1'b1 || {mem_addr, mem_wdata} !== {16'h0201, 18'h20002})
        $display("FAIL stall_hold%0d got we=%b %h/%h exp 1 0201/20002", k, mem_we, mem_addr,
                 mem_wdata);
      else n_pass++;
      tick();
    end
    mem_ready = 1'b1;
    n_total++;
    if ({mem_addr, mem_wdata} !== {16'h0201, 18'h20002})
      $display("FAIL stall_release got %h/%h exp 0201/20002", mem_addr, mem_wdata);
    else n_pass++;
    tick();
    n_total++;
    if ({mem_addr, mem_wdata} !== {16'h0202, 18'h30003})
      $display("FAIL stall_lane2 got %h/%h exp 0202/30003", mem_addr, mem_wdata);
    else n_pass++;
    tick();
    mem_ready = 1'b0;
    n_total++;
    if (done !== 1'b1 || mem_we !== 1'b0)
      $display("FAIL stall_done got done=%b we=%b exp 1,0", done, mem_we);
    else n_pass++;
  endtask

  task automatic test_flags_backpressure();
    logic [V-1:0][N-1:0] r1, r2;
    logic [AW+N-1:0] e;
    r1 = {18'h00333, 18'h00222, 18'h00111};
    r2 = {18'h3FFFF, 18'h2EEEE, 18'h1DDDD};
    exp_q.delete();
    load_model(r1, 3'b010, 16'h0100);
    in_valid = 1'b1; in_result = r1; in_flags = 4'b1010; in_op = 3'b010; in_addr = 16'h0100;
    mem_ready = 1'b1;
    tick();
    in_result = r2; in_flags = 4'b0101; in_op = 3'b000; in_addr = 16'h0200;
    for (int k = 0; k < V; k++) begin
      e = exp_q.pop_front();
      n_total++;
      if (flags_q !== 4'b1010 || in_ready !== 1'b0 || {mem_addr, mem_wdata} !== e)
        $display("FAIL bp_busy%0d got flags=%b rdy=%b %h/%h exp 1010 0 %h/%h", k, flags_q,
                 in_ready, mem_addr, mem_wdata, e[AW+N-1:N], e[N-1:0]);
      else n_pass++;
      tick();
    end
    n_total++;
    if (done !== 1'b1 || in_ready !== 1'b1 || flags_q !== 4'b1010)
      $display("FAIL bp_done got done=%b rdy=%b flags=%b exp 1,1,1010", done, in_ready, flags_q);
    else n_pass++;
    tick();
    in_valid = 1'b0;
    exp_q.delete();
    load_model(r2, 3'b000, 16'h0200);
    for (int k = 0; k < V; k++) begin
      e = exp_q.pop_front();
      n_total++;
      if (flags_q !== 4'b0101 || mem_we !== 1'b1 || {mem_addr, mem_wdata} !== e)
        $display("FAIL bp_second%0d got flags=%b we=%b %h/%h exp 0101 1 %h/%h", k, flags_q,
                 mem_we, mem_addr, mem_wdata, e[AW+N-1:N], e[N-1:0]);
      else n_pass++;
      tick();
    end
    mem_ready = 1'b0;
    n_total++;
    if (done !== 1'b1 || mem_we !== 1'b0)
      $display("FAIL bp_second_done got done=%b we=%b exp 1,0", done, mem_we);
    else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    in_valid = 1'b1; in_result = {18'h7, 18'h6, 18'h5}; in_flags = 4'b1111;
    in_op = 3'b000; in_addr = 16'h0300;
    mem_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    mem_ready = 1'b0;
    n_total++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h0301)
      $display("FAIL rst_mid_lane1 got we=%b addr=%h exp 1 0301", mem_we, mem_addr);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (mem_we !== 1'b0 || flags_q !== 4'b0 || busy !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL rst_mid_abort got we=%b flags=%b busy=%b rdy=%b exp 0,0000,0,0", mem_we,
               flags_q, busy, in_ready);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    mem_ready = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL rst_mid_ready got %b exp 1", in_ready);
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_total++;
      if (mem_we !== 1'b0 || done !== 1'b0)
        $display("FAIL rst_mid_quiet%0d got we=%b done=%b exp 0,0", k, mem_we, done);
      else n_pass++;
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [V-1:0][N-1:0] r;
    logic [2:0] op;
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < V; i++) r[i] = N'($urandom);
      op = ($urandom_range(3) == 0) ? 3'b101 : 3'($urandom_range(7));
      run_txn($sformatf("rand%0d", t), r, 4'($urandom), op, AW'($urandom),
              (t < 10) ? 0 : 35);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sum();
    test_wrap();
    test_stall();
    test_flags_backpressure();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
